// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter.
//   DATA_W / ADDR_W : default result and register-index widths
//   REG_ZERO        : hardwired-zero register index; writes to it are dropped
//   wb_entry_t      : one buffered writeback {rw, data}
package wb_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [ADDR_W-1:0] rw;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of wb_entry_t used to buffer mul/div results.
// Ports:
//   clk, rst_n        : clock, synchronous active-low reset (empties the FIFO)
//   push / din        : write an entry (ignored while full)
//   pop / dout        : drop the head entry (ignored while empty); dout is the head
//   full / empty      : occupancy flags
//   ent_valid/ent_rw  : per-slot occupancy and destination index, flat, for the
//                       pending-write scoreboard
// Pointers carry one extra MSB so full and empty are distinguishable.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      push,
  input  wb_entry_t                 din,
  input  logic                      pop,
  output wb_entry_t                 dout,
  output logic                      full,
  output logic                      empty,
  output logic [DEPTH-1:0]          ent_valid,
  output logic [DEPTH*ADDR_W-1:0]   ent_rw
);

  localparam int PW = $clog2(DEPTH);

  logic [PW:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0] count;
  logic        do_push, do_pop;
  wb_entry_t   mem_q [DEPTH];
  wb_entry_t   mem_d [DEPTH];

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign count = wr_ptr_q - rd_ptr_q;
  assign dout  = mem_q[rd_ptr_q[PW-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q + {{PW{1'b0}}, do_push};
    rd_ptr_d = rd_ptr_q + {{PW{1'b0}}, do_pop};
    mem_d    = mem_q;
    if (do_push) mem_d[wr_ptr_q[PW-1:0]] = din;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    logic [PW-1:0] offset;
    ent_valid = '0;
    ent_rw    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      offset       = PW'(i) - rd_ptr_q[PW-1:0];
      ent_valid[i] = ({1'b0, offset} < count);
      ent_rw[i*ADDR_W +: ADDR_W] = mem_q[i].rw;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: drives the register-file write port from the ALU
// (priority) and a FIFO of mul/div results, with starvation protection and
// a pending-write scoreboard for decode interlocks.
// Ports:
//   clk, rst_n                     : clock, synchronous active-low reset
//   alu_valid/alu_rw/alu_data      : ALU result; alu_stall=1 means it was not taken
//   md_valid/md_ready/md_rw/md_data: mul/div valid/ready handshake into the FIFO
//   q_rs/q_rt -> q_rs_pend/q_rt_pend : scoreboard queries
//   Rw/busW/RegWr                  : registered register-file write port
// Build option: define WB_BYPASS_EN to let a mul/div result skip the empty
// FIFO and load the output register directly when the ALU is idle.
module wb_arbiter
  import wb_pkg::wb_entry_t;
  import wb_pkg::REG_ZERO;
#(
  parameter int DATA_W     = wb_pkg::DATA_W,
  parameter int ADDR_W     = wb_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4,
  parameter int STARVE_MAX = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  input  logic [ADDR_W-1:0] alu_rw,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_stall,
  input  logic              md_valid,
  output logic              md_ready,
  input  logic [ADDR_W-1:0] md_rw,
  input  logic [DATA_W-1:0] md_data,
  input  logic [ADDR_W-1:0] q_rs,
  input  logic [ADDR_W-1:0] q_rt,
  output logic              q_rs_pend,
  output logic              q_rt_pend,
  output logic [ADDR_W-1:0] Rw,
  output logic [DATA_W-1:0] busW,
  output logic              RegWr
);

  localparam int SW = $clog2(STARVE_MAX + 1);

  logic                         fifo_full, fifo_empty;
  logic                         fifo_push, fifo_pop;
  wb_entry_t                    fifo_din, fifo_head;
  logic [FIFO_DEPTH-1:0]        ent_valid;
  logic [FIFO_DEPTH*ADDR_W-1:0] ent_rw;

  logic              head_zero, fifo_live, force_md;
  logic              alu_win, md_win, md_fire, bypass;

  logic [SW-1:0]     starve_q, starve_d;
  logic [ADDR_W-1:0] rw_q, rw_d;
  logic [DATA_W-1:0] bus_w_q, bus_w_d;
  logic              reg_wr_q, reg_wr_d;

  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (fifo_push),
    .din       (fifo_din),
    .pop       (fifo_pop),
    .dout      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .ent_valid (ent_valid),
    .ent_rw    (ent_rw)
  );

  always_comb begin
    // A head entry targeting r0 is discarded on the spot and never competes
    // for the write port, so it cannot stall the ALU or take a slot.
    head_zero = !fifo_empty && (fifo_head.rw == REG_ZERO);
    fifo_live = !fifo_empty && !head_zero;
    force_md  = (starve_q == SW'(STARVE_MAX)) && fifo_live;
    alu_win   = alu_valid && !force_md;
    md_win    = fifo_live && !alu_win;
    alu_stall = alu_valid && force_md;

    md_ready  = !fifo_full;
    md_fire   = md_valid && !fifo_full;
    bypass    = 1'b0;
`ifdef WB_BYPASS_EN
    bypass    = fifo_empty && !alu_valid && md_fire;
`endif
    fifo_push     = md_fire && !bypass;
    fifo_pop      = md_win || head_zero;
    fifo_din.rw   = md_rw;
    fifo_din.data = md_data;

    rw_d     = rw_q;
    bus_w_d  = bus_w_q;
    reg_wr_d = 1'b0;
    if (alu_win) begin
      if (alu_rw != '0) begin
        rw_d     = alu_rw;
        bus_w_d  = alu_data;
        reg_wr_d = 1'b1;
      end
    end else if (md_win) begin
      rw_d     = fifo_head.rw;
      bus_w_d  = fifo_head.data;
      reg_wr_d = 1'b1;
    end else if (bypass && (md_rw != '0)) begin
      rw_d     = md_rw;
      bus_w_d  = md_data;
      reg_wr_d = 1'b1;
    end

    starve_d = '0;
    if (fifo_live && alu_win) begin
      starve_d = (starve_q == SW'(STARVE_MAX)) ? starve_q : starve_q + 1'b1;
    end
  end

  always_comb begin
    q_rs_pend = reg_wr_q && (rw_q == q_rs);
    q_rt_pend = reg_wr_q && (rw_q == q_rt);
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (ent_valid[i] && (ent_rw[i*ADDR_W +: ADDR_W] == q_rs)) q_rs_pend = 1'b1;
      if (ent_valid[i] && (ent_rw[i*ADDR_W +: ADDR_W] == q_rt)) q_rt_pend = 1'b1;
    end
    if (q_rs == '0) q_rs_pend = 1'b0;
    if (q_rt == '0) q_rt_pend = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
      rw_q     <= '0;
      bus_w_q  <= '0;
      reg_wr_q <= 1'b0;
    end else begin
      starve_q <= starve_d;
      rw_q     <= rw_d;
      bus_w_q  <= bus_w_d;
      reg_wr_q <= reg_wr_d;
    end
  end

  assign Rw    = rw_q;
  assign busW  = bus_w_q;
  assign RegWr = reg_wr_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid, md_valid;
  logic [4:0]  alu_rw, md_rw, q_rs, q_rt;
  logic [31:0] alu_data, md_data;
  logic        alu_stall, md_ready, q_rs_pend, q_rt_pend, RegWr;
  logic [4:0]  Rw;
  logic [31:0] busW;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [4:0]  rw;
    logic [31:0] data;
  } ent_t;

  // Reference model state: a plain queue of outstanding mul/div results.
  ent_t        mq[$];
  int          m_starve;
  logic [4:0]  m_rw;
  logic [31:0] m_bus;
  logic        m_wr;

  always #5 clk = ~clk;

  wb_arbiter #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(4), .STARVE_MAX(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_rw(alu_rw), .alu_data(alu_data), .alu_stall(alu_stall),
    .md_valid(md_valid), .md_ready(md_ready), .md_rw(md_rw), .md_data(md_data),
    .q_rs(q_rs), .q_rt(q_rt), .q_rs_pend(q_rs_pend), .q_rt_pend(q_rt_pend),
    .Rw(Rw), .busW(busW), .RegWr(RegWr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    alu_valid = 1'b0; alu_rw = '0; alu_data = '0;
    md_valid  = 1'b0; md_rw  = '0; md_data  = '0;
    q_rs = '0; q_rt = '0;
  endtask

  task automatic do_reset();
    set_idle();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  function automatic bit model_pend(logic [4:0] q);
    bit p;
    p = m_wr && (m_rw == q);
    foreach (mq[i]) if (mq[i].rw == q) p = 1'b1;
    return p && (q != 0);
  endfunction

  task automatic test_reset();
    do_reset();
    q_rs = 5'd3; q_rt = 5'd0;
    #1;
    checks++; if ({RegWr, Rw, busW} !== 38'd0) begin errors++; $display("FAIL reset_out: got %0b/%0h/%0h expected 0/0/0", RegWr, Rw, busW); end
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL reset_md_ready: got %0b expected 1", md_ready); end
    checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL reset_alu_stall: got %0b expected 0", alu_stall); end
    checks++; if ({q_rs_pend, q_rt_pend} !== 2'b00) begin errors++; $display("FAIL reset_pend: got %0b%0b expected 00", q_rs_pend, q_rt_pend); end
    tick();
    checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL idle_regwr: got %0b expected 0", RegWr); end
  endtask

  task automatic test_alu_zero_data();
    do_reset();
    alu_valid = 1'b1; alu_rw = 5'd5; alu_data = 32'h0;
    #1;
    checks++; if (alu_stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0b expected 0", alu_stall); end
    tick();
    set_idle();
    checks++; if ({RegWr, Rw, busW} !== {1'b1, 5'd5, 32'h0}) begin errors++; $display("FAIL alu_write: got %0b/%0d/%0h expected 1/5/0", RegWr, Rw, busW); end
    tick();
    checks++; if ({RegWr, Rw} !== {1'b0, 5'd5}) begin errors++; $display("FAIL alu_hold: got %0b/%0d expected 0/5", RegWr, Rw); end
  endtask

  task automatic test_md_order();
    int exp_rw[6];
    int exp_dat[6];
    int exp_pend[6];
`ifdef WB_BYPASS_EN
    exp_rw   = '{7, 8, 9, 10, 0, 0};
    exp_dat  = '{'h11, 'h22, 'h33, 'h44, 0, 0};
    exp_pend = '{0, 0, 0, 1, 0, 0};
`else
    exp_rw   = '{0, 7, 8, 9, 10, 0};
    exp_dat  = '{0, 'h11, 'h22, 'h33, 'h44, 0};
    exp_pend = '{0, 0, 0, 1, 1, 0};
`endif
    do_reset();
    q_rs = 5'd9;
    for (int c = 0; c < 6; c++) begin
      md_valid = (c < 4);
      md_rw    = 5'(7 + c);
      md_data  = 32'h11 * (c + 1);
      #1;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL md_ready c%0d: got %0b expected 1", c, md_ready); end
      checks++; if (q_rs_pend !== exp_pend[c][0]) begin errors++; $display("FAIL md_pend c%0d: got %0b expected %0d", c, q_rs_pend, exp_pend[c]); end
      tick();
      md_valid = 1'b0;
      checks++;
      if (exp_rw[c] == 0) begin
        if (RegWr !== 1'b0) begin errors++; $display("FAIL md_order c%0d: got RegWr %0b expected 0", c, RegWr); end
      end else if ({RegWr, Rw, busW} !== {1'b1, 5'(exp_rw[c]), 32'(exp_dat[c])}) begin
        errors++; $display("FAIL md_order c%0d: got %0b/%0d/%0h expected 1/%0d/%0h", c, RegWr, Rw, busW, exp_rw[c], exp_dat[c]);
      end
    end
  endtask

  task automatic test_starvation();
    int acc = 0;
    do_reset();
    for (int c = 0; c < 6; c++) begin
      alu_valid = 1'b1; alu_rw = 5'd3; alu_data = 32'hA0 + acc;
      md_valid  = (c == 0); md_rw = 5'd12; md_data = 32'h55;
      #1;
      checks++; if (alu_stall !== (c == 4)) begin errors++; $display("FAIL starve_stall c%0d: got %0b expected %0b", c, alu_stall, (c == 4)); end
      tick();
      md_valid = 1'b0;
      checks++;
      if (c == 4) begin
        if ({RegWr, Rw, busW} !== {1'b1, 5'd12, 32'h55}) begin errors++; $display("FAIL starve_md: got %0b/%0d/%0h expected 1/12/55", RegWr, Rw, busW); end
      end else begin
        if ({RegWr, Rw, busW} !== {1'b1, 5'd3, 32'hA0 + acc}) begin errors++; $display("FAIL starve_alu c%0d: got %0b/%0d/%0h expected 1/3/%0h", c, RegWr, Rw, busW, 32'hA0 + acc); end
        acc++;
      end
    end
    set_idle();
  endtask

  task automatic test_reg_zero();
    do_reset();
    md_valid = 1'b1; md_rw = 5'd0; md_data = 32'h99;
    #1;
    checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL r0_handshake: got %0b expected 1", md_ready); end
    tick();
    set_idle();
    alu_valid = 1'b1; alu_rw = 5'd0; alu_data = 32'h77;
    #1;
    checks++; if ({alu_stall, q_rs_pend} !== 2'b00) begin errors++; $display("FAIL r0_stall_pend: got %0b%0b expected 00", alu_stall, q_rs_pend); end
    checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL r0_regwr c0: got %0b expected 0", RegWr); end
    tick();
    set_idle();
    for (int c = 1; c < 4; c++) begin
      checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL r0_regwr c%0d: got %0b expected 0", c, RegWr); end
      tick();
    end
  endtask

  task automatic test_reset_flush();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      alu_valid = 1'b1; alu_rw = 5'd1; alu_data = 32'(c);
      md_valid = 1'b1; md_rw = 5'(20 + c); md_data = 32'hC0 + c;
      #1;
      checks++; if (md_ready !== 1'b1) begin errors++; $display("FAIL fill_ready c%0d: got %0b expected 1", c, md_ready); end
      tick();
    end
    #1;
    checks++; if ({md_ready, alu_stall} !== 2'b01) begin errors++; $display("FAIL full_flags: got ready %0b stall %0b expected 0/1", md_ready, alu_stall); end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    set_idle();
    q_rs = 5'd20;
    #1;
    checks++; if ({RegWr, md_ready, q_rs_pend} !== 3'b010) begin errors++; $display("FAIL flush_state: got %0b%0b%0b expected 010", RegWr, md_ready, q_rs_pend); end
    for (int c = 0; c < 6; c++) begin
      tick();
      checks++; if (RegWr !== 1'b0) begin errors++; $display("FAIL flush_stale c%0d: got %0b expected 0", c, RegWr); end
    end
  endtask

  task automatic test_random();
    bit   hold_alu = 0, hold_md = 0;
    bit   live, hz, force_md, e_stall, e_ready, alu_w, md_w, byp;
    ent_t e;
    do_reset();
    mq.delete();
    m_starve = 0; m_rw = '0; m_bus = '0; m_wr = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if (!hold_alu) begin
        alu_valid = ($urandom_range(0, 1) == 1);
        alu_rw    = 5'($urandom_range(0, 7));
        alu_data  = $urandom;
      end
      if (!hold_md) begin
        md_valid = ($urandom_range(0, 9) < 4);
        md_rw    = 5'($urandom_range(1, 7));
        md_data  = $urandom;
      end
      q_rs = 5'($urandom_range(0, 7));
      q_rt = 5'($urandom_range(0, 7));
      #1;
      live     = (mq.size() > 0) && (mq[0].rw != 0);
      hz       = (mq.size() > 0) && (mq[0].rw == 0);
      force_md = (m_starve == 3) && live;
      e_stall  = alu_valid && force_md;
      e_ready  = (mq.size() < 4);
      checks++; if (alu_stall !== e_stall) begin errors++; $display("FAIL rnd_stall n%0d: got %0b expected %0b", n, alu_stall, e_stall); end
      checks++; if (md_ready !== e_ready) begin errors++; $display("FAIL rnd_ready n%0d: got %0b expected %0b", n, md_ready, e_ready); end
      checks++; if ({q_rs_pend, q_rt_pend} !== {model_pend(q_rs), model_pend(q_rt)}) begin
        errors++; $display("FAIL rnd_pend n%0d: got %0b%0b expected %0b%0b", n, q_rs_pend, q_rt_pend, model_pend(q_rs), model_pend(q_rt));
      end
      checks++; if ({RegWr, Rw, busW} !== {m_wr, m_rw, m_bus}) begin
        errors++; $display("FAIL rnd_out n%0d: got %0b/%0d/%0h expected %0b/%0d/%0h", n, RegWr, Rw, busW, m_wr, m_rw, m_bus);
      end
      alu_w = alu_valid && !force_md;
      md_w  = live && !alu_w;
      byp   = 1'b0;
`ifdef WB_BYPASS_EN
      byp   = (mq.size() == 0) && !alu_valid && md_valid && e_ready;
`endif
      m_wr = 1'b0;
      if (alu_w) begin
        if (alu_rw != 0) begin m_wr = 1'b1; m_rw = alu_rw; m_bus = alu_data; end
      end else if (md_w) begin
        m_wr = 1'b1; m_rw = mq[0].rw; m_bus = mq[0].data;
      end else if (byp && md_rw != 0) begin
        m_wr = 1'b1; m_rw = md_rw; m_bus = md_data;
      end
      m_starve = (live && alu_w) ? ((m_starve < 3) ? m_starve + 1 : 3) : 0;
      if (md_w || hz) void'(mq.pop_front());
      if (md_valid && e_ready && !byp) begin
        e.rw = md_rw; e.data = md_data;
        mq.push_back(e);
      end
      hold_alu = e_stall;
      hold_md  = md_valid && !e_ready;
      tick();
    end
    set_idle();
  endtask

  initial begin
    set_idle();
    test_reset();
    test_alu_zero_data();
    test_md_order();
    test_starvation();
    test_reg_zero();
    test_reset_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
